mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if.sv | 109 ++++++++++
 tb/tb_mem_bus_if.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Memory bus interface: MAR/MDR registers and an SRAM access sequencer (IDLE -> RD_ACC/WR_ACC -> DONE).
// Define MEM_WAIT_EN to stretch the access phase to WAIT_CYCLES clocks; otherwise it lasts one clock.
module mem_bus_if #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Bus,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        R,
    output logic        Busy,
    output logic [1:0]  state_dbg
);

    // Handshake: MEM_REQ (with MEM_WE) is accepted only on an edge where Busy=0; while Busy=1
    // MEM_REQ, LD_MAR and LD_MDR are dropped, and R is a single-cycle completion pulse.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_ACC = 2'd1;
    localparam logic [1:0] WR_ACC = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_bus_if: WAIT_CYCLES must be in 1..15");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       acc_last;
    logic       in_acc;

    assign in_acc = (state == RD_ACC) || (state == WR_ACC);

`ifdef MEM_WAIT_EN
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
    logic [3:0] wait_cnt;

    // Held at zero in IDLE so every access starts counting from 0; stops at LAST_CNT, never wraps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= 4'd0;
        end else if (state == IDLE) begin
            wait_cnt <= 4'd0;
        end else if (in_acc && !acc_last) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign acc_last = (wait_cnt == LAST_CNT);
`else
    assign acc_last = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           if (MEM_REQ) state_nxt = MEM_WE ? WR_ACC : RD_ACC;
            RD_ACC, WR_ACC: if (acc_last) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loads land on the same edge that starts an access, so the access sees the fresh value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            MAR <= 16'h0000;
            MDR <= 16'h0000;
        end else begin
            if (state == IDLE && LD_MAR) begin
                MAR <= Bus;
            end
            if (state == IDLE && LD_MDR) begin
                MDR <= Bus;
            end else if (state == RD_ACC && acc_last) begin
                MDR <= Data_from_SRAM;
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset releases them immediately.
    assign CE_n         = !in_acc;
    assign OE_n         = (state != RD_ACC);
    assign WE_n         = (state != WR_ACC);
    assign R            = (state == DONE);
    assign Busy         = (state != IDLE);
    assign ADDR         = {4'h0, MAR};
    assign Data_to_SRAM = MDR;
    assign state_dbg    = state;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: directed transaction table, reset-abort sequence, and random
// cycles checked against a timeline model; follows MEM_WAIT_EN the same way the design does.
module tb_mem_bus_if;

`ifdef MEM_WAIT_EN
    localparam int WAIT = 2;
    localparam int W    = WAIT;
`else
    localparam int WAIT = 5;
    localparam int W    = 1;
`endif
    localparam int OW = 16 + 16 + 20 + 16 + 5;

    localparam logic [2:0] K_LDMAR   = 3'd0;
    localparam logic [2:0] K_LDMDR   = 3'd1;
    localparam logic [2:0] K_READ    = 3'd2;
    localparam logic [2:0] K_WRITE   = 3'd3;
    localparam logic [2:0] K_BUSYRD  = 3'd4;
    localparam logic [2:0] K_LDREAD  = 3'd5;
    localparam logic [2:0] K_LDWRITE = 3'd6;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] bus;
        logic [15:0] sram;
        logic [15:0] exp_mar;
        logic [15:0] exp_mdr;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Bus;
    logic        LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
    logic [15:0] Data_from_SRAM;
    logic [15:0] MAR, MDR, Data_to_SRAM;
    logic [19:0] ADDR;
    logic        CE_n, OE_n, WE_n, R, Busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];
    vec_t vecs[7];

    mem_bus_if #(.WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .Data_from_SRAM(Data_from_SRAM),
        .MAR(MAR), .MDR(MDR), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
        .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .R(R), .Busy(Busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    task automatic apply_reset();
        Reset = 1'b0;
        Bus = '0; LD_MAR = 0; LD_MDR = 0; MEM_REQ = 0; MEM_WE = 0; Data_from_SRAM = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] pack(input logic [15:0] mar, input logic [15:0] mdr,
                                           input logic [19:0] addr, input logic [15:0] dout,
                                           input logic ce, input logic oe, input logic we,
                                           input logic r, input logic busy);
        return {mar, mdr, addr, dout, ce, oe, we, r, busy};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, {29'd0, CE_n, OE_n, WE_n}, 32'h7);
        check({tag, "_r"}, {31'd0, R}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    // ---------------- directed driver ----------------
    task automatic run_vec(input vec_t v, input logic [15:0] prev_mdr);
        logic is_acc, is_wr;
        logic [15:0] mdr_during;
        int acc_n, r_n, r_idx, i;
        is_acc = v.kind inside {K_READ, K_WRITE, K_BUSYRD, K_LDREAD, K_LDWRITE};
        is_wr  = (v.kind == K_WRITE) || (v.kind == K_LDWRITE);
        mdr_during = is_wr ? v.exp_mdr : prev_mdr;
        @(negedge Clk);
        Bus = v.bus;
        Data_from_SRAM = v.sram;
        LD_MAR  = (v.kind == K_LDMAR) || (v.kind == K_LDREAD);
        LD_MDR  = (v.kind == K_LDMDR) || (v.kind == K_LDWRITE);
        MEM_REQ = is_acc;
        MEM_WE  = is_wr;
        @(posedge Clk); #1;
        LD_MAR = 0; LD_MDR = 0; MEM_REQ = 0;
        if (is_acc) begin
            acc_n = 0; r_n = 0; r_idx = -1;
            for (i = 0; i < 40 && Busy; i++) begin
                if (!CE_n) begin
                    acc_n++;
                    check("acc_addr", {12'd0, ADDR}, {16'd0, 4'h0, v.exp_mar});
                    check("acc_oe_we", {30'd0, OE_n, WE_n}, is_wr ? 32'h2 : 32'h1);
                    check("acc_mdr_stable", {16'd0, MDR}, {16'd0, mdr_during});
                    if (is_wr) check("acc_wdata", {16'd0, Data_to_SRAM}, {16'd0, v.exp_mdr});
                end
                if (R) begin
                    r_n++;
                    r_idx = i;
                end
                if (v.kind == K_BUSYRD) begin
                    // Loads and a second request while busy; must all be dropped.
                    LD_MAR = !R; MEM_REQ = !R; Bus = R ? 16'h0000 : 16'hFFFF;
                end
                @(posedge Clk); #1;
            end
            LD_MAR = 0; MEM_REQ = 0;
            check("acc_timeout", {31'd0, Busy}, 32'd0);
            check("acc_cycles", acc_n, W);
            check("r_pulses", r_n, 1);
            check("r_latency", r_idx, W);
            check_idle_outputs("post_acc");
        end
        check("mar", {16'd0, MAR}, {16'd0, v.exp_mar});
        check("mdr", {16'd0, MDR}, {16'd0, v.exp_mdr});
        check("addr", {12'd0, ADDR}, {16'd0, 4'h0, v.exp_mar});
        check("data_to_sram", {16'd0, Data_to_SRAM}, {16'd0, v.exp_mdr});
    endtask

    // Reset asserted mid-read: strobes must release at once, no completion afterwards.
    task automatic reset_mid_access();
        int r_seen;
        @(negedge Clk);
        LD_MAR = 1; Bus = 16'h7777;
        @(negedge Clk);
        LD_MAR = 0; MEM_REQ = 1; MEM_WE = 0; Data_from_SRAM = 16'h9999;
        @(posedge Clk); #1;
        MEM_REQ = 0;
        check("rst_pre_oe", {31'd0, OE_n}, 32'd0);
        #2 Reset = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        check("rst_mar", {16'd0, MAR}, 32'd0);
        check("rst_mdr", {16'd0, MDR}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        r_seen = 0;
        repeat (W + 3) begin
            @(posedge Clk); #1;
            if (R || Busy) r_seen++;
        end
        check("rst_no_r", r_seen, 0);
        check("rst_mdr_after", {16'd0, MDR}, 32'd0);
    endtask

    // ---------------- random phase with timeline model ----------------
    // The model records the edge index of each accepted request; every output then follows
    // from the distance d to that edge: access for d in 0..W-1, completion at d==W.
    task automatic random_phase(input int ncyc);
        logic [15:0] m_mar, m_mdr;
        logic m_we;
        int n, e_req, d, d_prev;
        logic acc, done;
        logic [OW-1:0] exp_v, act_v;
        m_mar = '0; m_mdr = '0; m_we = 0; n = 0; e_req = -100;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            LD_MAR  = ($urandom_range(0, 3) == 0);
            LD_MDR  = ($urandom_range(0, 3) == 0);
            MEM_REQ = ($urandom_range(0, 2) == 0);
            MEM_WE  = $urandom_range(0, 1) == 1;
            Bus            = 16'($urandom);
            Data_from_SRAM = 16'($urandom);
            @(posedge Clk);
            n++;
            d_prev = n - 1 - e_req;
            if (d_prev > W) begin
                if (LD_MAR) m_mar = Bus;
                if (LD_MDR) m_mdr = Bus;
                if (MEM_REQ) begin
                    e_req = n;
                    m_we = MEM_WE;
                end
            end else if (d_prev == W - 1 && !m_we) begin
                m_mdr = Data_from_SRAM;
            end
            d = n - e_req;
            acc  = (d >= 0) && (d <= W - 1);
            done = (d == W);
            exp_q.push_back(pack(m_mar, m_mdr, {4'h0, m_mar}, m_mdr, !acc,
                                 !(acc && !m_we), !(acc && m_we), done, acc || done));
            #1;
            act_v = pack(MAR, MDR, ADDR, Data_to_SRAM, CE_n, OE_n, WE_n, R, Busy);
            exp_v = exp_q.pop_front();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rand_cycle_%0d: got %h expected %h", c, act_v, exp_v);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{K_LDMAR,   16'h1234, 16'h0000, 16'h1234, 16'h0000};
        vecs[1] = '{K_READ,    16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[2] = '{K_LDMDR,   16'hA5A5, 16'h0000, 16'h1234, 16'hA5A5};
        vecs[3] = '{K_WRITE,   16'h0000, 16'h1111, 16'h1234, 16'hA5A5};
        vecs[4] = '{K_BUSYRD,  16'h0000, 16'h0F0F, 16'h1234, 16'h0F0F};
        vecs[5] = '{K_LDREAD,  16'h0042, 16'hCAFE, 16'h0042, 16'hCAFE};
        vecs[6] = '{K_LDWRITE, 16'h5A5A, 16'h2222, 16'h0042, 16'h5A5A};

        apply_reset();
        #1;
        check_idle_outputs("reset");
        check("reset_mar", {16'd0, MAR}, 32'd0);
        check("reset_mdr", {16'd0, MDR}, 32'd0);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], (k == 0) ? 16'h0000 : vecs[k-1].exp_mdr);
        end

        reset_mid_access();

        apply_reset();
        random_phase(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
